// File: rtl/act_stream_engine.sv
// act_stream_engine
//   Multi-lane activation unit. Accepts a burst of `count` vectors over a
//   valid/ready handshake and applies the activation selected at start:
//   bypass, ReLU, clamped ReLU or leaky ReLU. Each result vector is written
//   to the destination buffer at base_addr + k*LANES. The input-to-write
//   latency is a fixed two cycles.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle pulse, begins a burst when idle
//   mode, clamp_max,
//   leak_shift,
//   base_addr, count    burst configuration, captured on start
//   in_valid/in_ready   input handshake; in_data holds LANES packed elements
//   wr_en               destination write strobe
//   out_dest_addr       destination address for out_data
//   out_data            activated vector, packed the same way as in_data
//   busy                high whenever the block is not idle
//   done                one-cycle pulse at the end of a burst
module act_stream_engine #(
  parameter int BIT_DEPTH       = 8,
  parameter int LANES           = 2,
  parameter int DEST_ADDR_WIDTH = 10,
  parameter int CNT_WIDTH       = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [1:0]                     mode,
  input  logic [BIT_DEPTH-1:0]           clamp_max,
  input  logic [2:0]                     leak_shift,
  input  logic [DEST_ADDR_WIDTH-1:0]     base_addr,
  input  logic [CNT_WIDTH-1:0]           count,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANES*BIT_DEPTH-1:0]     in_data,
  output logic                           wr_en,
  output logic [DEST_ADDR_WIDTH-1:0]     out_dest_addr,
  output logic [LANES*BIT_DEPTH-1:0]     out_data,
  output logic                           busy,
  output logic                           done
);

  localparam int DW = LANES * BIT_DEPTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_reg, state_next;

  // Burst configuration captured on start
  logic [1:0]                  mode_reg;
  logic signed [BIT_DEPTH-1:0] cm_reg;
  logic [2:0]                  shift_reg;
  logic [CNT_WIDTH-1:0]        count_reg;

  // Burst progress
  logic [CNT_WIDTH-1:0]        accepted_reg;
  logic [DEST_ADDR_WIDTH-1:0]  addr_reg;

  // Pipeline stages
  logic                        s1_valid_reg;
  logic [DW-1:0]               s1_data_reg;
  logic [DEST_ADDR_WIDTH-1:0]  s1_addr_reg;
  logic                        wr_en_reg;
  logic [DW-1:0]               out_data_reg;
  logic [DEST_ADDR_WIDTH-1:0]  out_addr_reg;
  logic [DW-1:0]               act_data;

  logic start_ok;
  logic xfer;

  assign start_ok = (state_reg == IDLE) && start;
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    done       = 1'b0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (start) state_next = (count == '0) ? DONE : RUN;
      end
      RUN: begin
        in_ready = (accepted_reg < count_reg);
        if (in_valid && in_ready && (accepted_reg + CNT_WIDTH'(1) == count_reg))
          state_next = DRAIN;
      end
      DRAIN: begin
        // Stage 1 empty while stage 2 writes means this is the final write.
        if (wr_en_reg && !s1_valid_reg) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A negative clamp bound collapses to zero once, here, so the lane
  // logic only ever compares against a non-negative ceiling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg  <= '0;
      cm_reg    <= '0;
      shift_reg <= '0;
      count_reg <= '0;
    end else if (start_ok) begin
      mode_reg  <= mode;
      cm_reg    <= clamp_max[BIT_DEPTH-1] ? '0 : clamp_max;
      shift_reg <= leak_shift;
      count_reg <= count;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accepted_reg <= '0;
      addr_reg     <= '0;
    end else if (start_ok) begin
      accepted_reg <= '0;
      addr_reg     <= base_addr;
    end else if (xfer) begin
      accepted_reg <= accepted_reg + CNT_WIDTH'(1);
      addr_reg     <= addr_reg + DEST_ADDR_WIDTH'(LANES);
    end
  end

  // Stage 1: capture the accepted vector and its destination address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_addr_reg  <= '0;
    end else begin
      s1_valid_reg <= xfer;
      if (xfer) begin
        s1_data_reg <= in_data;
        s1_addr_reg <= addr_reg;
      end
    end
  end

  // Per-lane activation on the stage-1 vector
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [BIT_DEPTH-1:0] x;
      logic signed [BIT_DEPTH-1:0] y;
      assign x = s1_data_reg[gi*BIT_DEPTH +: BIT_DEPTH];
      always_comb begin
        y = x;
        case (mode_reg)
          2'd1: if (x[BIT_DEPTH-1]) y = '0;
          2'd2: begin
            if (x[BIT_DEPTH-1])  y = '0;
            else if (x > cm_reg) y = cm_reg;
          end
          2'd3: if (x[BIT_DEPTH-1]) y = x >>> shift_reg;
          default: y = x;
        endcase
      end
      assign act_data[gi*BIT_DEPTH +: BIT_DEPTH] = y;
    end
  endgenerate

  // Stage 2: write strobe; data and address hold between writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_reg    <= 1'b0;
      out_data_reg <= '0;
      out_addr_reg <= '0;
    end else begin
      wr_en_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_data_reg <= act_data;
        out_addr_reg <= s1_addr_reg;
      end
    end
  end

  assign wr_en         = wr_en_reg;
  assign out_data      = out_data_reg;
  assign out_dest_addr = out_addr_reg;

endmodule

// File: tb/tb_act_stream_engine.sv
// Testbench for act_stream_engine: scoreboard of expected writes (address,
// data, cycle) pushed on each accepted transfer and popped on each wr_en.
module tb_act_stream_engine;

  localparam int BD = 8;
  localparam int LN = 2;
  localparam int AW = 10;
  localparam int CW = 10;
  localparam int DW = LN * BD;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [BD-1:0] clamp_max = '0;
  logic [2:0]    leak_shift = '0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] count = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          wr_en;
  logic [AW-1:0] out_dest_addr;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  act_stream_engine #(
    .BIT_DEPTH(BD), .LANES(LN), .DEST_ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .clamp_max(clamp_max),
    .leak_shift(leak_shift), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_en(wr_en), .out_dest_addr(out_dest_addr), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] vec_q[$];
  bit            gap_q[$];
  bit            mid_start = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int wr_cnt   = 0;

  int cur_mode, cur_cm, cur_ls, cur_base, cur_n, start_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference activation in plain integer arithmetic
  function automatic logic [BD-1:0] act_lane(input int m, input int cm, input int ls, input int x);
    int y;
    int c;
    int d;
    c = (cm < 0) ? 0 : cm;
    d = 1 << ls;
    case (m)
      0: y = x;
      1: y = (x < 0) ? 0 : x;
      2: y = (x < 0) ? 0 : ((x > c) ? c : x);
      default: y = (x < 0) ? -((-x + d - 1) / d) : x;   // floor(x / 2^ls)
    endcase
    return y[BD-1:0];
  endfunction

  function automatic logic [DW-1:0] exp_vec(input logic [DW-1:0] v);
    logic [DW-1:0]        r;
    logic signed [BD-1:0] xs;
    r = '0;
    for (int l = 0; l < LN; l++) begin
      xs = v[l*BD +: BD];
      r[l*BD +: BD] = act_lane(cur_mode, cur_cm, cur_ls, int'(xs));
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] pack(input int a0, input int a1);
    logic [BD-1:0] l0;
    logic [BD-1:0] l1;
    l0 = a0[BD-1:0];
    l1 = a1[BD-1:0];
    return {l1, l0};
  endfunction

  // Write monitor: every wr_en must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) done_cnt++;
    if (!rst && wr_en) begin
      wr_cnt++;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: cycle=%0d addr=%h data=%h, required no write",
                 cyc, out_dest_addr, out_data);
      end else begin
        e = sb_q.pop_front();
        if (out_dest_addr !== e.addr || out_data !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL write: got addr=%h data=%h cycle=%0d, required addr=%h data=%h cycle=%0d",
                   out_dest_addr, out_data, cyc, e.addr, e.data, e.cyc);
        end else begin
          $display("write addr=%h data=%h cycle=%0d ok", out_dest_addr, out_data, cyc);
        end
      end
    end
  end

  task automatic start_burst(input int m, input int cm, input int ls, input int base, input int n);
    @(negedge clk);
    start      = 1'b1;
    mode       = m[1:0];
    clamp_max  = cm[BD-1:0];
    leak_shift = ls[2:0];
    base_addr  = base[AW-1:0];
    count      = n[CW-1:0];
    cur_mode = m; cur_cm = cm; cur_ls = ls; cur_base = base; cur_n = n;
    start_cyc = cyc;
    @(negedge clk);
    start      = 1'b0;
    // Scramble the configuration inputs; the burst must not see them
    mode       = 2'($urandom);
    clamp_max  = BD'($urandom);
    leak_shift = 3'($urandom);
    base_addr  = AW'($urandom);
    count      = CW'($urandom);
  endtask

  task automatic feed(output int last_xfer);
    int   idx;
    int   p;
    int   a;
    exp_t e;
    idx = 0; p = 0; a = cur_base; last_xfer = -1;
    while (idx < cur_n && p < 200) begin
      in_valid = (p < gap_q.size()) ? gap_q[p] : 1'b1;
      in_data  = in_valid ? vec_q[idx] : DW'($urandom);
      start    = mid_start && (p == 1);
      if (in_valid && in_ready) begin
        e.addr = a[AW-1:0];
        e.data = exp_vec(vec_q[idx]);
        e.cyc  = cyc + 2;
        sb_q.push_back(e);
        last_xfer = cyc;
        idx++;
        a = (a + LN) % (1 << AW);
      end
      p++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (idx < cur_n) begin
      n_checks++;
      n_fail++;
      $display("FAIL feed_timeout: accepted %0d vectors, required %0d", idx, cur_n);
    end
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({in_ready, wr_en, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got in_ready/wr_en/busy/done=%b, required 0000",
               {in_ready, wr_en, busy, done});
    end
    n_checks++;
    if (out_dest_addr !== '0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h data=%h, required 0/0", out_dest_addr, out_data);
    end
    rst = 1'b0;
    $display("reset released at cycle %0d", cyc);
  endtask

  task automatic test_relu();
    int lx, dc, d0, w0;
    vec_q = {pack(5, -3), pack(-128, 127), pack(0, -1)};
    gap_q.delete(); mid_start = 1'b0;
    d0 = done_cnt; w0 = wr_cnt;
    start_burst(1, 0, 0, 'h010, 3);
    feed(lx);
    wait_done(dc);
    n_checks++;
    if (dc != lx + 3) begin
      n_fail++;
      $display("FAIL relu_done_cycle: got %0d, required %0d", dc, lx + 3);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (wr_cnt - w0 != 3 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL relu_counts: got writes=%0d dones=%0d, required 3/1", wr_cnt - w0, done_cnt - d0);
    end
    $display("relu burst finished, done at cycle %0d", dc);
  endtask

  task automatic test_clamp();
    int lx, dc, w0;
    vec_q = {pack(7, 6), pack(-2, 3)};
    gap_q.delete(); mid_start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      w0 = wr_cnt;
      start_burst(2, (r == 0) ? 6 : -4, 0, 'h100, 2);
      feed(lx);
      wait_done(dc);
      repeat (2) @(negedge clk);
      n_checks++;
      if (dc != lx + 3 || wr_cnt - w0 != 2) begin
        n_fail++;
        $display("FAIL clamp_burst%0d: got done_cycle=%0d writes=%0d, required %0d/2",
                 r, dc, wr_cnt - w0, lx + 3);
      end
      $display("clamp burst %0d finished at cycle %0d", r, dc);
    end
  endtask

  task automatic test_leaky();
    int lx, dc, w0;
    vec_q = {pack(-8, -1), pack(-5, 9), pack(-128, 127)};
    gap_q.delete(); mid_start = 1'b0;
    w0 = wr_cnt;
    start_burst(3, 0, 2, 'h200, 3);
    feed(lx);
    wait_done(dc);
    repeat (2) @(negedge clk);
    n_checks++;
    if (dc != lx + 3 || wr_cnt - w0 != 3) begin
      n_fail++;
      $display("FAIL leaky_burst: got done_cycle=%0d writes=%0d, required %0d/3", dc, wr_cnt - w0, lx + 3);
    end
    $display("leaky burst finished at cycle %0d", dc);
  endtask

  task automatic test_gaps();
    int lx, dc, d0, w0;
    vec_q = {pack(100, -100), pack(-7, 3)};
    gap_q = {1'b1, 1'b0, 1'b0, 1'b1};
    mid_start = 1'b1;
    d0 = done_cnt; w0 = wr_cnt;
    start_burst(1, 0, 0, 'h040, 2);
    feed(lx);
    mid_start = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_in_ready: got %b after last transfer, required 0", in_ready);
    end
    wait_done(dc);
    repeat (4) @(negedge clk);
    n_checks++;
    if (dc != lx + 3 || wr_cnt - w0 != 2 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL gaps_burst: got done_cycle=%0d writes=%0d dones=%0d, required %0d/2/1",
               dc, wr_cnt - w0, done_cnt - d0, lx + 3);
    end
    $display("gapped burst finished at cycle %0d", dc);
  endtask

  task automatic test_wrap();
    int lx, dc, w0;
    vec_q = {pack(1, 2), pack(-3, 4)};
    gap_q.delete(); mid_start = 1'b0;
    w0 = wr_cnt;
    start_burst(0, 0, 0, 'h3FE, 2);
    feed(lx);
    wait_done(dc);
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_dest_addr !== 10'h000 || wr_cnt - w0 != 2) begin
      n_fail++;
      $display("FAIL wrap: got last addr=%h writes=%0d, required 000/2", out_dest_addr, wr_cnt - w0);
    end
    $display("wrap burst finished at cycle %0d", dc);
  endtask

  task automatic test_count_zero();
    int dc, d0, w0;
    d0 = done_cnt; w0 = wr_cnt;
    start_burst(1, 0, 0, 'h080, 0);
    wait_done(dc);
    n_checks++;
    if (dc != start_cyc + 1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done: got done_cycle=%0d busy=%b, required %0d/1", dc, busy, start_cyc + 1);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done_cnt - d0 != 1 || wr_cnt - w0 != 0) begin
      n_fail++;
      $display("FAIL zero_after: got busy=%b dones=%0d writes=%0d, required 0/1/0",
               busy, done_cnt - d0, wr_cnt - w0);
    end
    $display("zero-length burst finished at cycle %0d", dc);
  endtask

  task automatic test_reset_abort();
    int lx, dc, d0, w0;
    vec_q = {pack(1, -1), pack(2, -2), pack(3, -3), pack(4, -4)};
    gap_q.delete(); mid_start = 1'b0;
    d0 = done_cnt; w0 = wr_cnt;
    start_burst(1, 0, 0, 'h300, 4);
    feed(lx);
    n_checks++;
    if (busy !== 1'b1 || wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: got busy=%b wr_en=%b in DRAIN, required 1/1", busy, wr_en);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({wr_en, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_async: got wr_en/busy/done=%b, required 000", {wr_en, busy, done});
    end
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 != 0 || wr_cnt - w0 != 3 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_after: got dones=%0d writes=%0d busy=%b, required 0/3/0",
               done_cnt - d0, wr_cnt - w0, busy);
    end
    vec_q = {pack(-9, 9), pack(50, -50)};
    w0 = wr_cnt;
    start_burst(1, 0, 0, 'h020, 2);
    feed(lx);
    wait_done(dc);
    repeat (2) @(negedge clk);
    n_checks++;
    if (dc != lx + 3 || wr_cnt - w0 != 2) begin
      n_fail++;
      $display("FAIL abort_restart: got done_cycle=%0d writes=%0d, required %0d/2", dc, wr_cnt - w0, lx + 3);
    end
    $display("post-abort burst finished at cycle %0d", dc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_relu();
    test_clamp();
    test_leaky();
    test_gaps();
    test_wrap();
    test_count_zero();
    test_reset_abort();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_writes: %0d expected writes never appeared, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/act_stream_engine.md
Name: act_stream_engine

Overview:
- Parametrised multi-lane activation unit; successor to the two-lane ReLU write-back block.
- Accepts a burst of COUNT input vectors (LANES signed elements each) from the line-buffer side over a valid/ready handshake.
- Applies a run-time-selected activation (bypass, ReLU, clamped ReLU, leaky ReLU) and writes each result vector to the destination buffer at auto-incrementing addresses.
- Sits between the convolution/line-buffer output and the destination feature-map memory.

Parameters:
- BIT_DEPTH, 8, width of each signed two's-complement element.
- LANES, 2, elements processed per cycle (>=1).
- DEST_ADDR_WIDTH, 10, destination address width.
- CNT_WIDTH, 10, width of the burst-length field.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a burst when idle
- mode  in  2  0=bypass, 1=ReLU, 2=clamped ReLU, 3=leaky ReLU; sampled at start
- clamp_max  in  BIT_DEPTH  signed upper bound for mode 2; sampled at start
- leak_shift  in  3  arithmetic right-shift amount for mode 3; sampled at start
- base_addr  in  DEST_ADDR_WIDTH  address of first result vector; sampled at start
- count  in  CNT_WIDTH  number of vectors in the burst; sampled at start
- in_valid  in  1  in_data is valid
- in_ready  out  1  block can accept in_data this cycle
- in_data  in  LANES*BIT_DEPTH  lane i at bits [i*BIT_DEPTH +: BIT_DEPTH]
- wr_en  out  1  destination write strobe
- out_dest_addr  out  DEST_ADDR_WIDTH  destination address for out_data
- out_data  out  LANES*BIT_DEPTH  activated vector, same lane packing as in_data
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at end of burst

Behaviour:
- Reset:
  - State goes to IDLE.
  - in_ready, wr_en, busy and done are 0.
  - out_dest_addr and out_data are 0.
  - Pipeline valid bits and counters are cleared.
  - Reset mid-burst aborts the burst immediately; no further writes and no done pulse.
- States:
  - IDLE: start=1 latches mode, clamp_max, leak_shift, base_addr and count. Go to RUN, or to DONE if count==0.
  - RUN: in_ready=1 while accepted<count. A transfer occurs when in_valid&&in_ready. When the transfer that makes accepted==count occurs, go to DRAIN.
  - DRAIN: in_ready=0. Go to DONE in the cycle after the last wr_en pulse.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored when not in IDLE.
- busy=1 in RUN, DRAIN and DONE.
- Pipeline, two register stages with fixed latency 2:
  - Stage 1 registers the accepted vector and its address, base_addr + k*LANES for the k-th transfer (k from 0).
  - Stage 2 registers the activated data and address, and sets wr_en=1 for one cycle.
  - A transfer on cycle t produces wr_en on cycle t+2.
  - Back-to-back transfers give back-to-back wr_en pulses.
  - Destination has no backpressure.
- Between writes: wr_en=0; out_data and out_dest_addr hold their last values.
- Address arithmetic is modulo 2^DEST_ADDR_WIDTH; wrap is silent.
- Activation, per lane, x signed BIT_DEPTH:
  - mode 0: y=x.
  - mode 1: y = x<0 ? 0 : x.
  - mode 2: y = x<0 ? 0 : (x>cm ? cm : x), where cm = clamp_max if clamp_max>=0, else 0.
  - mode 3: y = x<0 ? (x >>> leak_shift) : x. Arithmetic shift, so the sign is kept and the result rounds toward -inf. leak_shift=0 behaves as bypass.
  - The result always fits BIT_DEPTH; no saturation is needed beyond the above.
- Lanes are independent and identical; no cross-lane logic.
- in_valid while in_ready=0 is ignored. The source must hold in_data until the transfer occurs.
- Input changes to mode, clamp_max, leak_shift, base_addr or count during a burst have no effect.

Test Plan:
1. ReLU, LANES=2, count=3, base_addr=0x010, in_valid held high, vectors {5,-3},{-128,127},{0,-1}.
   - wr_en on 3 consecutive cycles, starting 2 cycles after the first transfer.
   - Writes: addr 0x010 data {5,0}; addr 0x012 {0,127}; addr 0x014 {0,0}.
   - done pulses the cycle after the last write.
2. Clamped ReLU, clamp_max=6, inputs {7,6},{-2,3} -> {6,6},{0,3}. Repeat with clamp_max=-4 -> all outputs 0.
3. Leaky ReLU, leak_shift=2, inputs {-8,-1},{-5,9} -> {-2,-1},{-2,9}.
4. Handshake gaps: in_valid toggles 1,0,0,1, count=2.
   - Exactly 2 writes, each 2 cycles after its transfer.
   - in_ready drops after the 2nd transfer.
   - start pulsed mid-burst has no effect.
5. Wrap and edge cases:
   - base_addr=0x3FE, count=2, LANES=2 -> addresses 0x3FE, then 0x000.
   - count=0 -> IDLE, DONE, IDLE with done pulsed once and no wr_en.
6. rst asserted asynchronously during DRAIN -> wr_en, busy and done drop immediately; no done pulse; next start runs normally from base_addr.
